alu_checker: RTL and testbench

- Synthesizable consumer-side result checker for the RV32 single-cycle ALU.
- Samples the ALU operands, control op and outputs, and recomputes the expected result with an internal reference model.
- Flags mismatches, keeps check and error statistics, and freezes a snapshot of the first failing transaction.
- Sits on the ALU output bus in simulation and FPGA debug builds; it never drives the datapath.

---
 rtl/alu_checker.sv | 118 +++++++++++
 tb/tb_alu_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_checker.sv
// Consumer-side result checker for the RV32 single-cycle ALU: recomputes the result,
// counts checks/errors and freezes the first failure. Optional macro: ALU_CHECKER_ZERO_CHECK_EN.
module alu_checker #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [3:0]       alu_control_op_i,
  input  logic [XLEN-1:0]  a_num_i,
  input  logic [XLEN-1:0]  b_num_i,
  input  logic [XLEN-1:0]  c_num_i,
  input  logic             zero_i,
  output logic             result_valid_o,
  output logic             mismatch_o,
  output logic             illegal_op_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] check_count_o,
  output logic [CNT_W-1:0] error_count_o,
  output logic             err_captured_o,
  output logic [3:0]       err_op_o,
  output logic [XLEN-1:0]  err_a_o,
  output logic [XLEN-1:0]  err_b_o,
  output logic [XLEN-1:0]  err_c_o,
  output logic [XLEN-1:0]  err_exp_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] expected;
  logic            op_legal;
  logic            exp_zero;
  logic            mis_now;
  logic            active;
  logic            check_now;
  logic            fail_now;
  logic            sync_clr;

  // Reference model of the ALU ops this checker understands.
  always_comb begin
    op_legal = 1'b1;
    expected = '0;
    case (alu_control_op_i)
      4'b0000: expected = a_num_i & b_num_i;
      4'b0001: expected = a_num_i | b_num_i;
      4'b0010: expected = a_num_i + b_num_i;
      4'b0110: expected = a_num_i - b_num_i;
      default: op_legal = 1'b0;
    endcase
  end

  assign exp_zero = (expected == '0);

`ifdef ALU_CHECKER_ZERO_CHECK_EN
  assign mis_now = (c_num_i != expected) || (zero_i != exp_zero);
`else
  // Zero flag is intentionally ignored in this build; the masked term keeps it referenced.
  assign mis_now = (c_num_i != expected) || (zero_i & exp_zero & 1'b0);
`endif

  assign sync_clr  = rst_i || clear_i;
  assign active    = valid_i && (state == ST_RUN);
  assign check_now = active && op_legal;
  assign fail_now  = check_now && mis_now;
  assign halted_o  = (state == ST_HALTED);

  always_ff @(posedge clk_i) begin
    if (sync_clr) state <= ST_RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:     if (fail_now && (HALT_ON_ERR != 0)) state_next = ST_HALTED;
      ST_HALTED:  state_next = ST_HALTED;
      default:    state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      result_valid_o <= 1'b0;
      mismatch_o     <= 1'b0;
      illegal_op_o   <= 1'b0;
      check_count_o  <= '0;
      error_count_o  <= '0;
      err_captured_o <= 1'b0;
      err_op_o       <= '0;
      err_a_o        <= '0;
      err_b_o        <= '0;
      err_c_o        <= '0;
      err_exp_o      <= '0;
    end else begin
      result_valid_o <= check_now;
      mismatch_o     <= fail_now;
      illegal_op_o   <= active && !op_legal;
      if (check_now && (check_count_o != {CNT_W{1'b1}}))
        check_count_o <= check_count_o + CNT_W'(1);
      if (fail_now && (error_count_o != {CNT_W{1'b1}}))
        error_count_o <= error_count_o + CNT_W'(1);
      // Snapshot only the first failure since the last reset/clear.
      if (fail_now && !err_captured_o) begin
        err_captured_o <= 1'b1;
        err_op_o       <= alu_control_op_i;
        err_a_o        <= a_num_i;
        err_b_o        <= b_num_i;
        err_c_o        <= c_num_i;
        err_exp_o      <= expected;
      end
    end
  end

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: directed vector table, halt/clear sequence and randomized
// traffic scored against a high-level model (three instances: default, halting, 2-bit counters).
module tb_alu_checker;

  logic        clk = 1'b0;
  logic        rst, clr, valid, z;
  logic [3:0]  op;
  logic [31:0] a, b, c;

  always #5 clk = ~clk;

  // Default instance
  logic        d0_rv, d0_mis, d0_ill, d0_halt, d0_cap;
  logic [15:0] d0_chk, d0_err;
  logic [3:0]  d0_eop;
  logic [31:0] d0_ea, d0_eb, d0_ec, d0_ee;
  // Halting instance
  logic        h_rv, h_mis, h_ill, h_halt, h_cap;
  logic [15:0] h_chk, h_err;
  logic [3:0]  h_eop;
  logic [31:0] h_ea, h_eb, h_ec, h_ee;
  // Narrow-counter instance
  logic        s_rv, s_mis, s_ill, s_halt, s_cap;
  logic [1:0]  s_chk, s_err;
  logic [3:0]  s_eop;
  logic [31:0] s_ea, s_eb, s_ec, s_ee;

  alu_checker #(.XLEN(32), .CNT_W(16), .HALT_ON_ERR(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(valid), .alu_control_op_i(op),
    .a_num_i(a), .b_num_i(b), .c_num_i(c), .zero_i(z),
    .result_valid_o(d0_rv), .mismatch_o(d0_mis), .illegal_op_o(d0_ill), .halted_o(d0_halt),
    .check_count_o(d0_chk), .error_count_o(d0_err), .err_captured_o(d0_cap),
    .err_op_o(d0_eop), .err_a_o(d0_ea), .err_b_o(d0_eb), .err_c_o(d0_ec), .err_exp_o(d0_ee));

  alu_checker #(.XLEN(32), .CNT_W(16), .HALT_ON_ERR(1)) u_dut_halt (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(valid), .alu_control_op_i(op),
    .a_num_i(a), .b_num_i(b), .c_num_i(c), .zero_i(z),
    .result_valid_o(h_rv), .mismatch_o(h_mis), .illegal_op_o(h_ill), .halted_o(h_halt),
    .check_count_o(h_chk), .error_count_o(h_err), .err_captured_o(h_cap),
    .err_op_o(h_eop), .err_a_o(h_ea), .err_b_o(h_eb), .err_c_o(h_ec), .err_exp_o(h_ee));

  alu_checker #(.XLEN(32), .CNT_W(2), .HALT_ON_ERR(0)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(valid), .alu_control_op_i(op),
    .a_num_i(a), .b_num_i(b), .c_num_i(c), .zero_i(z),
    .result_valid_o(s_rv), .mismatch_o(s_mis), .illegal_op_o(s_ill), .halted_o(s_halt),
    .check_count_o(s_chk), .error_count_o(s_err), .err_captured_o(s_cap),
    .err_op_o(s_eop), .err_a_o(s_ea), .err_b_o(s_eb), .err_c_o(s_ec), .err_exp_o(s_ee));

`ifdef ALU_CHECKER_ZERO_CHECK_EN
  localparam bit ZERO_MIS = 1'b1;
`else
  localparam bit ZERO_MIS = 1'b0;
`endif

  typedef struct packed {
    logic        rv, mis, ill, cap;
    logic [15:0] chk, err;
    logic [1:0]  s_chk, s_err;
    logic [3:0]  eop;
    logic [31:0] ea, eb, ec, ee;
  } obs_t;

  typedef struct {
    bit          v;
    logic [3:0]  op;
    logic [31:0] a, b, c;
    bit          z;
    bit          e_rv, e_mis, e_ill;
  } vec_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Model state: raw (unsaturated) counts, first-failure snapshot
  int          m_chk, m_err;
  bit          m_cap;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_c, m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r);
    longint unsigned two32 = 64'h1_0000_0000;
    longint unsigned xx = x, yy = y;
    r = '0;
    case (o)
      4'd0: begin r = x & y; return 1'b1; end
      4'd1: begin r = x | y; return 1'b1; end
      4'd2: begin r = 32'((xx + yy) % two32); return 1'b1; end
      4'd6: begin r = 32'((xx + two32 - yy) % two32); return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic model_reset();
    m_chk = 0; m_err = 0; m_cap = 0;
    m_op = '0; m_a = '0; m_b = '0; m_c = '0; m_e = '0;
  endtask

  // Predict the outputs one edge after the current inputs are sampled.
  task automatic model_step(output obs_t o);
    logic [31:0] r;
    bit legal, bad;
    o = '0;
    if (rst || clr) begin
      model_reset();
      return;
    end
    legal = ref_op(op, a, b, r);
    bad   = (c != r) || (ZERO_MIS && (z != (r == 0)));
    if (valid && legal) begin
      o.rv = 1'b1;
      m_chk++;
      if (bad) begin
        o.mis = 1'b1;
        m_err++;
        if (!m_cap) begin
          m_cap = 1; m_op = op; m_a = a; m_b = b; m_c = c; m_e = r;
        end
      end
    end
    o.ill   = valid && !legal;
    o.chk   = 16'(sat(m_chk, 65535));
    o.err   = 16'(sat(m_err, 65535));
    o.s_chk = 2'(sat(m_chk, 3));
    o.s_err = 2'(sat(m_err, 3));
    o.cap = m_cap; o.eop = m_op; o.ea = m_a; o.eb = m_b; o.ec = m_c; o.ee = m_e;
  endtask

  task automatic compare_all();
    obs_t e;
    e = exp_q.pop_front();
    chk("result_valid", d0_rv, e.rv);
    chk("mismatch", d0_mis, e.mis);
    chk("illegal_op", d0_ill, e.ill);
    chk("halted", d0_halt, 1'b0);
    chk("check_count", d0_chk, e.chk);
    chk("error_count", d0_err, e.err);
    chk("err_captured", d0_cap, e.cap);
    chk("err_op", d0_eop, e.eop);
    chk("err_a", d0_ea, e.ea);
    chk("err_b", d0_eb, e.eb);
    chk("err_c", d0_ec, e.ec);
    chk("err_exp", d0_ee, e.ee);
    chk("sat_check_count", s_chk, e.s_chk);
    chk("sat_error_count", s_err, e.s_err);
  endtask

  // Drive one cycle at the falling edge, then compare after the next rising edge.
  task automatic cycle(input bit r, input bit cl, input bit v, input logic [3:0] o,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] res,
                       input bit zf);
    obs_t e;
    rst = r; clr = cl; valid = v; op = o; a = x; b = y; c = res; z = zf;
    model_step(e);
    exp_q.push_back(e);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_halt_dut(input string tag, input bit e_rv, input bit e_mis,
                                input bit e_halt, input int e_chk, input int e_err);
    chk({tag, "_rv"}, h_rv, e_rv);
    chk({tag, "_mis"}, h_mis, e_mis);
    chk({tag, "_ill"}, h_ill, 1'b0);
    chk({tag, "_halted"}, h_halt, e_halt);
    chk({tag, "_chk"}, h_chk, 16'(e_chk));
    chk({tag, "_err"}, h_err, 16'(e_err));
  endtask

  vec_t vecs[7];

  initial begin
    rst = 1'b1; clr = 1'b0; valid = 1'b0; op = '0; a = '0; b = '0; c = '0; z = 1'b0;
    model_reset();

    vecs[0] = '{1, 4'd2, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1, 0, 0};
    vecs[1] = '{1, 4'd6, 32'd5,         32'd7,         32'hFFFF_FFFE, 0, 1, 0, 0};
    vecs[2] = '{1, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F001, 0, 1, 1, 0};
    vecs[3] = '{1, 4'd1, 32'h1,         32'h2,         32'h0,         0, 1, 1, 0};
    vecs[4] = '{1, 4'd3, 32'h1,         32'h2,         32'h3,         0, 0, 0, 1};
    vecs[5] = '{0, 4'd0, 32'h0,         32'h0,         32'h5,         0, 0, 0, 0};
    vecs[6] = '{1, 4'd6, 32'd9,         32'd9,         32'h0,         0, 1, ZERO_MIS, 0};

    // Reset with a valid transaction present: reset must win.
    @(negedge clk);
    cycle(1, 0, 1, 4'd0, 32'h1, 32'h1, 32'h0, 0);
    check_halt_dut("rst_halt_dut", 0, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].z);
      chk($sformatf("vec%0d_rv", i), d0_rv, vecs[i].e_rv);
      chk($sformatf("vec%0d_mis", i), d0_mis, vecs[i].e_mis);
      chk($sformatf("vec%0d_ill", i), d0_ill, vecs[i].e_ill);
      if (i == 0) chk("vec0_check_count", d0_chk, 16'd1);
      if (i == 2) begin
        chk("vec2_err_exp", d0_ee, 32'hF000_F000);
        chk("vec2_err_c", d0_ec, 32'hF000_F001);
        chk("vec2_err_count", d0_err, 16'd1);
      end
      if (i == 3) begin
        chk("vec3_err_op_kept", d0_eop, 4'd0);
        chk("vec3_err_count", d0_err, 16'd2);
      end
      if (i == 4) begin
        chk("vec4_check_count", d0_chk, 16'd4);
        chk("vec4_err_count", d0_err, 16'd2);
      end
    end

    // Halt sequence: clear, one failure, then three passing transactions.
    cycle(0, 1, 0, 4'd0, 32'h0, 32'h0, 32'h0, 0);
    check_halt_dut("clr1", 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 4'd0, 32'hF, 32'h3, 32'h0, 0);
    check_halt_dut("halt_entry", 1, 1, 1, 1, 1);
    chk("halt_snapshot_exp", h_ee, 32'h3);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 4'd2, 32'h1, 32'h1, 32'h2, 0);
      check_halt_dut($sformatf("halted%0d", i), 0, 0, 1, 1, 1);
    end
    cycle(0, 0, 1, 4'd9, 32'h1, 32'h1, 32'h2, 0);
    check_halt_dut("halted_illegal", 0, 0, 1, 1, 1);
    cycle(0, 1, 1, 4'd0, 32'h1, 32'h1, 32'h0, 0);
    check_halt_dut("clr2", 0, 0, 0, 0, 0);
    chk("clr2_captured", h_cap, 1'b0);
    chk("clr2_err_exp", h_ee, 32'h0);

    // Randomized traffic, back-to-back, with occasional clears.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb, rr;
      bit          rv, rc, rz;
      int          sel;
      sel = $urandom_range(0, 9);
      ro  = (sel < 2) ? 4'd0 : (sel < 4) ? 4'd1 : (sel < 6) ? 4'd2 : (sel < 8) ? 4'd6
          : 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      void'(ref_op(ro, ra, rb, rr));
      rz  = (rr == 0);
      if ($urandom_range(0, 7) == 0) rr = rr ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rz = !rz;
      rv  = ($urandom_range(0, 4) != 0);
      rc  = ($urandom_range(0, 99) < 2);
      cycle(0, rc, rv, ro, ra, rb, rr, rz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
